byte_enable_gen: RTL and testbench

Store byte-enable generator for the MEM stage of the pipelined MIPS CPU. It decodes the store type and the low two address bits into a 4-bit per-byte write enable, aligns the store data onto the matching byte lanes, and optionally flags misaligned stores. All outputs are registered, so they present to data memory one cycle after the store leaves EX.

---
 rtl/mem_pkg.sv | 11 +
 rtl/byte_enable_gen_if.sv | 23 ++
 rtl/byte_enable_gen_be_decode.sv | 38 +++
 rtl/byte_enable_gen.sv | 54 +++++
 tb/tb_byte_enable_gen.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared MEM-stage constants: store-type encodings and data lane geometry.
package mem_pkg;
   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_W    = 2'b01;
   localparam logic [1:0] ST_H    = 2'b10;
   localparam logic [1:0] ST_B    = 2'b11;

   localparam int LANES  = 4;
   localparam int BYTE_W = 8;
   localparam int DATA_W = LANES * BYTE_W;
endpackage

// File: rtl/byte_enable_gen_if.sv
// Store bus between EX/MEM control and data memory write port.
// Handshake: no valid/ready; every non-stalled edge consumes one store request and st_signal=00 marks an idle slot.
interface byte_enable_gen_if;
   import mem_pkg::*;

   logic              stall;
   logic [1:0]        st_signal;
   logic [1:0]        offset;
   logic [DATA_W-1:0] wdata_in;
   logic [LANES-1:0]  BE;
   logic [DATA_W-1:0] wdata_out;
   logic              misalign;

   modport master (
      output stall, st_signal, offset, wdata_in,
      input  BE, wdata_out, misalign
   );

   modport slave (
      input  stall, st_signal, offset, wdata_in,
      output BE, wdata_out, misalign
   );
endinterface

// File: rtl/byte_enable_gen_be_decode.sv
// Combinational store-type/offset decode to byte enables and misalign flag.
// Alignment checking is compiled in only when BE_ALIGN_EXC_EN is defined.
module be_decode
   import mem_pkg::*;
(
   input  logic [1:0]       st_signal_i,
   input  logic [1:0]       offset_i,
   output logic [LANES-1:0] be_o,
   output logic             misalign_o
);

   always_comb begin
      be_o       = '0;
      misalign_o = 1'b0;
      case (st_signal_i)
         ST_W: begin
`ifdef BE_ALIGN_EXC_EN
            if (offset_i != 2'b00) misalign_o = 1'b1;
            else                   be_o       = 4'b1111;
`else
            be_o = 4'b1111;
`endif
         end
         ST_H: begin
`ifdef BE_ALIGN_EXC_EN
            if (offset_i[0])       misalign_o = 1'b1;
            else if (offset_i[1])  be_o       = 4'b1100;
            else                   be_o       = 4'b0011;
`else
            be_o = offset_i[1] ? 4'b1100 : 4'b0011;
`endif
         end
         ST_B:    be_o = 4'b0001 << offset_i;
         default: be_o = '0;
      endcase
   end

endmodule

// File: rtl/byte_enable_gen.sv
// MEM-stage store byte-enable generator: registered BE, lane-aligned data, misalign flag.
// Build with BE_ALIGN_EXC_EN defined to suppress and flag misaligned stores.
module byte_enable_gen
   import mem_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   byte_enable_gen_if.slave bus
);

   logic [LANES-1:0]  be_d, be_q;
   logic              misalign_d, misalign_q;
   logic [DATA_W-1:0] raw_d, wdata_d, wdata_q;

   be_decode u_be_decode (
      .st_signal_i (bus.st_signal),
      .offset_i    (bus.offset),
      .be_o        (be_d),
      .misalign_o  (misalign_d)
   );

   // Place data on lanes first, then zero every lane the decode did not enable.
   always_comb begin
      raw_d = '0;
      case (bus.st_signal)
         ST_W:    raw_d = bus.wdata_in;
         ST_H:    raw_d = bus.offset[1] ? {bus.wdata_in[15:0], 16'h0000}
                                        : {16'h0000, bus.wdata_in[15:0]};
         ST_B:    raw_d = {24'h000000, bus.wdata_in[7:0]} << {bus.offset, 3'b000};
         default: raw_d = '0;
      endcase
      wdata_d = '0;
      for (int i = 0; i < LANES; i++) begin
         wdata_d[i*BYTE_W +: BYTE_W] = be_d[i] ? raw_d[i*BYTE_W +: BYTE_W] : 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         be_q       <= '0;
         wdata_q    <= '0;
         misalign_q <= 1'b0;
      end else if (!bus.stall) begin
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.BE        = be_q;
   assign bus.wdata_out = wdata_q;
   assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_byte_enable_gen.sv
// Self-checking bench for byte_enable_gen; expectations come from a per-lane reference model.
module tb_byte_enable_gen;
   import mem_pkg::*;

   logic clk;
   logic rst_n;
   byte_enable_gen_if bus();

   byte_enable_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   logic [36:0] exp_q[$];
   logic [36:0] last_exp = '0;

   task automatic check_eq(input string tag, input logic [36:0] got, input logic [36:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got BE=%b wd=%h mis=%b, expected BE=%b wd=%h mis=%b",
                    tag, got[36:33], got[32:1], got[0], exp[36:33], exp[32:1], exp[0]);
   endtask

   // Reference model, written lane by lane: {BE, wdata_out, misalign}.
   function automatic logic [36:0] model(input logic [1:0] st, input logic [1:0] off,
                                         input logic [31:0] d);
      logic [3:0]  be;
      logic [31:0] wd;
      logic        mis;
      be  = 4'b0000;
      wd  = 32'h0;
      mis = 1'b0;
`ifdef BE_ALIGN_EXC_EN
      mis = (st == ST_W && off != 2'b00) || (st == ST_H && off[0]);
`endif
      for (int i = 0; i < 4; i++) begin
         case (st)
            ST_W: be[i] = 1'b1;
            ST_H: be[i] = ((i / 2) == int'(off[1]));
            ST_B: be[i] = (i == int'(off));
            default: be[i] = 1'b0;
         endcase
         if (mis) be[i] = 1'b0;
         if (be[i]) begin
            case (st)
               ST_W:    wd[8*i +: 8] = d[8*i +: 8];
               ST_H:    wd[8*i +: 8] = d[8*(i%2) +: 8];
               default: wd[8*i +: 8] = d[7:0];
            endcase
         end
      end
      return {be, wd, mis};
   endfunction

   function automatic logic [36:0] observed();
      return {bus.BE, bus.wdata_out, bus.misalign};
   endfunction

   task automatic step(input string tag, input logic s, input logic [1:0] st,
                       input logic [1:0] off, input logic [31:0] d);
      @(negedge clk);
      bus.stall     = s;
      bus.st_signal = st;
      bus.offset    = off;
      bus.wdata_in  = d;
      if (!s) last_exp = model(st, off, d);
      exp_q.push_back(last_exp);
      @(posedge clk);
      #1;
      check_eq(tag, observed(), exp_q.pop_front());
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.stall     = 1'b0;
      bus.st_signal = ST_NONE;
      bus.offset    = 2'b00;
      bus.wdata_in  = 32'h0;
      #2;
      check_eq("reset_async", observed(), 37'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("idle0", 1'b0, ST_NONE, 2'b00, 32'hFFFF_FFFF);
      step("idle1", 1'b0, ST_NONE, 2'b11, 32'h1234_5678);

      for (int o = 0; o < 4; o++)
         step($sformatf("sb_off%0d", o), 1'b0, ST_B, o[1:0], 32'h0000_00AB);

      step("sh_off0", 1'b0, ST_H, 2'b00, 32'h1234_BEEF);
      check_eq("sh_off0_lit", observed(), {4'b0011, 32'h0000_BEEF, 1'b0});
      step("sh_off2", 1'b0, ST_H, 2'b10, 32'h1234_BEEF);
      check_eq("sh_off2_lit", observed(), {4'b1100, 32'hBEEF_0000, 1'b0});
      step("sw_off0", 1'b0, ST_W, 2'b00, 32'h1234_BEEF);
      check_eq("sw_off0_lit", observed(), {4'b1111, 32'h1234_BEEF, 1'b0});

      step("sw_off1", 1'b0, ST_W, 2'b01, 32'hCAFE_F00D);
`ifdef BE_ALIGN_EXC_EN
      check_eq("sw_mis_lit", observed(), {4'b0000, 32'h0, 1'b1});
`else
      check_eq("sw_mis_lit", observed(), {4'b1111, 32'hCAFE_F00D, 1'b0});
`endif
      step("sh_off3", 1'b0, ST_H, 2'b11, 32'hCAFE_F00D);
`ifdef BE_ALIGN_EXC_EN
      check_eq("sh_mis_lit", observed(), {4'b0000, 32'h0, 1'b1});
`else
      check_eq("sh_mis_lit", observed(), {4'b1100, 32'hF00D_0000, 1'b0});
`endif

      step("stall_pre", 1'b0, ST_B, 2'b10, 32'h0000_0055);
      for (int k = 0; k < 3; k++)
         step($sformatf("stall_hold%0d", k), 1'b1, ST_W, 2'b00, 32'h9999_0000 + k);
      check_eq("stall_lit", observed(), {4'b0100, 32'h0055_0000, 1'b0});
      step("stall_release", 1'b0, ST_W, 2'b00, 32'h7777_8888);

      for (int r = 0; r < 24; r++)
         step($sformatf("rand%0d", r), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

      step("pre_rst_sw", 1'b0, ST_W, 2'b00, 32'hA5A5_5A5A);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_midop", observed(), 37'd0);
      last_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_idle", 1'b0, ST_NONE, 2'b00, 32'hDEAD_BEEF);
      step("post_rst_sb", 1'b0, ST_B, 2'b01, 32'h0000_00C3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
